// File: rtl/pipe_perf_monitor.sv
// Run controller and performance counters for the 5-stage core: run to an instruction limit, drain, then hold results.
// Optional watchdog (define PERF_WATCHDOG_EN) aborts a run that stops retiring for WDOG_CYCLES cycles.
module pipe_perf_monitor #(
  parameter int CNT_W          = 32,
  parameter int PC_W           = 32,
  parameter int PIPELINE_DEPTH = 5,
  parameter int FORW_W         = 2,
  parameter int WDOG_CYCLES    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  instr_limit,
  input  logic              wb_isValid,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic              id_stall,
  input  logic [FORW_W-1:0] id_forwA,
  input  logic [FORW_W-1:0] id_forwB,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [PC_W-1:0]   last_pc,
  output logic              sat,
  output logic              timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int DRAIN_W = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPELINE_DEPTH - 1);

  if (PIPELINE_DEPTH < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("pipe_perf_monitor: PIPELINE_DEPTH and WDOG_CYCLES must be >= 1");
  end

  // Returns {overflowed, clamped sum}; the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, a} + {{CNT_W{1'b0}}, inc};
    if (sum > {2'b00, CNT_MAX}) sat_add = {1'b1, CNT_MAX};
    else                        sat_add = {1'b0, sum[CNT_W-1:0]};
  endfunction

  logic [1:0]         state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   limit_q;
  logic [1:0]         fwd_inc;
  logic [CNT_W:0]     cyc_nx, ret_nx, stall_nx, fwd_nx;
  logic               any_sat, limit_hit, start_ok, wdog_fire;

  always_comb begin
    fwd_inc  = 2'(id_forwA != '0) + 2'(id_forwB != '0);
    cyc_nx   = sat_add(cycle_cnt, 2'd1);
    ret_nx   = sat_add(retired_cnt, {1'b0, wb_isValid});
    stall_nx = sat_add(stall_cnt, {1'b0, id_stall});
    fwd_nx   = sat_add(fwd_cnt, fwd_inc);
    any_sat  = cyc_nx[CNT_W] | ret_nx[CNT_W] | stall_nx[CNT_W] | fwd_nx[CNT_W];
    limit_hit = wb_isValid && (ret_nx[CNT_W-1:0] == limit_q);
  end

  assign start_ok = start && (state == IDLE || state == DONE);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

`ifdef PERF_WATCHDOG_EN
  localparam int IDLE_W = $clog2(WDOG_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the cycle whose idle increment would reach WDOG_CYCLES.
  assign wdog_fire = (state == RUN) && !wb_isValid && (idle_cnt == IDLE_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (start_ok) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (state == RUN) begin
      idle_cnt <= wb_isValid ? '0 : idle_cnt + 1'b1;
      if (wdog_fire) timeout <= 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      limit_q     <= '0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      stall_cnt   <= '0;
      fwd_cnt     <= '0;
      last_pc     <= '0;
      sat         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            limit_q     <= instr_limit;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
            fwd_cnt     <= '0;
            last_pc     <= '0;
            sat         <= 1'b0;
            if (instr_limit == '0) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          cycle_cnt   <= cyc_nx[CNT_W-1:0];
          retired_cnt <= ret_nx[CNT_W-1:0];
          stall_cnt   <= stall_nx[CNT_W-1:0];
          fwd_cnt     <= fwd_nx[CNT_W-1:0];
          if (wb_isValid) last_pc <= wb_pc;
          sat <= sat | any_sat;
          // The limiting retirement and its cycle are counted before draining.
          if (limit_hit) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else if (wdog_fire) begin
            state <= DONE;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= DONE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Randomised and directed bench for pipe_perf_monitor against a counting reference model.
// A second 4-bit-counter instance shares the stimulus for the saturation case.
module tb_pipe_perf_monitor;
  localparam int CW = 32;
  localparam int PW = 32;
  localparam int PD = 5;
  localparam int FW = 2;
  localparam int WD = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset, start, wb_isValid, id_stall;
  logic [CW-1:0] instr_limit;
  logic [PW-1:0] wb_pc;
  logic [FW-1:0] id_forwA, id_forwB;

  logic          busy, done, sat, timeout;
  logic [CW-1:0] cycle_cnt, retired_cnt, stall_cnt, fwd_cnt;
  logic [PW-1:0] last_pc;

  logic          s_busy, s_done, s_sat, s_timeout;
  logic [SW-1:0] s_cycle_cnt, s_retired_cnt, s_stall_cnt, s_fwd_cnt;
  logic [PW-1:0] s_last_pc;

  int vectors = 0;
  int miscompares = 0;

  longint e_cyc, e_ret, e_stall, e_fwd, e_pc;
  bit     e_fired;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.CNT_W(CW), .PC_W(PW), .PIPELINE_DEPTH(PD), .FORW_W(FW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_limit(instr_limit),
    .wb_isValid(wb_isValid), .wb_pc(wb_pc), .id_stall(id_stall),
    .id_forwA(id_forwA), .id_forwB(id_forwB),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt), .last_pc(last_pc), .sat(sat), .timeout(timeout)
  );

  pipe_perf_monitor #(.CNT_W(SW), .PC_W(PW), .PIPELINE_DEPTH(PD), .FORW_W(FW), .WDOG_CYCLES(WD)) dut_small (
    .clk(clk), .reset(reset), .start(start), .instr_limit(instr_limit[SW-1:0]),
    .wb_isValid(wb_isValid), .wb_pc(wb_pc), .id_stall(id_stall),
    .id_forwA(id_forwA), .id_forwB(id_forwB),
    .busy(s_busy), .done(s_done), .cycle_cnt(s_cycle_cnt), .retired_cnt(s_retired_cnt),
    .stall_cnt(s_stall_cnt), .fwd_cnt(s_fwd_cnt), .last_pc(s_last_pc), .sat(s_sat), .timeout(s_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // mode 0 random, 1 fixed retire/stall/forward pattern, 2 retire every cycle, 3 two retires then silence
  task automatic set_inputs(input int mode, input int c);
    start       = ($urandom_range(0, 7) == 0);
    instr_limit = $urandom;
    id_stall    = $urandom_range(0, 1);
    wb_pc       = $urandom;
    case (mode)
      1: begin
        wb_isValid = (c == 2 || c == 5 || c == 9);
        id_stall   = (c == 3 || c == 4);
        id_forwA   = (c == 6) ? 2'd1 : 2'd0;
        id_forwB   = (c == 6) ? 2'd2 : 2'd0;
        wb_pc      = 32'h100 + 32'(c * 4);
      end
      2: begin
        wb_isValid = 1'b1;
        id_forwA   = 2'($urandom_range(1, 3));
        id_forwB   = 2'($urandom_range(1, 3));
        wb_pc      = 32'h1000 + 32'(c * 4);
      end
      3: begin
        wb_isValid = (c <= 2);
        id_forwA   = 2'd0;
        id_forwB   = 2'd0;
      end
      default: begin
        wb_isValid = ($urandom_range(0, 3) != 0);
        id_forwA   = 2'($urandom_range(0, 3));
        id_forwB   = 2'($urandom_range(0, 3));
      end
    endcase
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cyc"}, cycle_cnt, 0);
    check({tag, "_ret"}, retired_cnt, 0);
    check({tag, "_stall"}, stall_cnt, 0);
    check({tag, "_fwd"}, fwd_cnt, 0);
    check({tag, "_pc"}, last_pc, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_s_busy"}, s_busy, 0);
    check({tag, "_s_fwd"}, s_fwd_cnt, 0);
  endtask

  task automatic do_run(input string tag, input int lim, input int mode, input bit chk_small);
    bit v, st, hit;
    logic [FW-1:0] fa, fb;
    logic [PW-1:0] pc;
    int idle, c, k;
    bit e_sat;
    set_inputs(0, 0);
    start       = 1'b1;
    instr_limit = CW'(lim);
    step();
    e_cyc = 0; e_ret = 0; e_stall = 0; e_fwd = 0; e_pc = 0;
    e_fired = 1'b0; idle = 0; c = 0;
    hit = (lim == 0);
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_cyc"}, cycle_cnt, 0);
    check({tag, "_start_timeout"}, timeout, 0);
    check({tag, "_start_sat"}, sat, 0);
    while (!hit && !e_fired && c < 300) begin
      c++;
      set_inputs(mode, c);
      v = wb_isValid; st = id_stall; fa = id_forwA; fb = id_forwB; pc = wb_pc;
      step();
      e_cyc++;
      e_stall += st;
      e_fwd += (fa != 0) + (fb != 0);
      if (v) begin e_ret++; e_pc = pc; idle = 0; end
      else idle++;
      if (e_ret == lim) hit = 1'b1;
`ifdef PERF_WATCHDOG_EN
      else if (idle == WD) e_fired = 1'b1;
`endif
      if (!hit && !e_fired) check({tag, "_run_busy"}, busy, 1);
    end
    check({tag, "_run_ended"}, hit | e_fired, 1);
    k = 0;
    if (!e_fired) begin
      for (int i = 1; i <= 20; i++) begin
        check({tag, "_drain_busy"}, busy, 1);
        set_inputs(0, 0);
        step();
        k = i;
        if (done) break;
      end
      check({tag, "_drain_len"}, k, PD);
    end
    start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_cyc"}, cycle_cnt, e_cyc);
      check({tag, "_ret"}, retired_cnt, e_ret);
      check({tag, "_stall"}, stall_cnt, e_stall);
      check({tag, "_fwd"}, fwd_cnt, e_fwd);
      check({tag, "_pc"}, last_pc, e_pc);
      check({tag, "_sat"}, sat, 0);
      check({tag, "_timeout"}, timeout, e_fired);
      if (chk_small) begin
        e_sat = (e_cyc > 15) || (e_ret > 15) || (e_stall > 15) || (e_fwd > 15);
        check({tag, "_s_done"}, s_done, 1);
        check({tag, "_s_cyc"}, s_cycle_cnt, clampw(e_cyc, SW));
        check({tag, "_s_ret"}, s_retired_cnt, clampw(e_ret, SW));
        check({tag, "_s_stall"}, s_stall_cnt, clampw(e_stall, SW));
        check({tag, "_s_fwd"}, s_fwd_cnt, clampw(e_fwd, SW));
        check({tag, "_s_sat"}, s_sat, e_sat);
      end
      set_inputs(0, 0);
      start = 1'b0;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    set_inputs(0, 0);
    start = 1'b1;
    step();
    step();
    check_zero("reset");
    reset = 1'b0;
    start = 1'b0;
    step();
    check_zero("idle");

    // Reset mid-run wins over a simultaneous start.
    set_inputs(0, 0);
    start = 1'b1;
    instr_limit = 20;
    step();
    for (int i = 1; i <= 7; i++) begin
      set_inputs(2, i);
      step();
    end
    check("t1_cyc_before", cycle_cnt, 7);
    reset = 1'b1;
    start = 1'b1;
    step();
    check_zero("t1");
    reset = 1'b0;
    start = 1'b0;
    step();

    do_run("t2", 4, 2, 1'b0);
    check("t2_cyc_const", cycle_cnt, 4);
    check("t2_ret_const", retired_cnt, 4);
    check("t2_pc_const", last_pc, 32'h1010);

    do_run("t3", 3, 1, 1'b0);
    check("t3_cyc_const", cycle_cnt, 9);
    check("t3_stall_const", stall_cnt, 2);
    check("t3_fwd_const", fwd_cnt, 2);

    do_run("t4", 0, 0, 1'b0);
    check("t4_ret_const", retired_cnt, 0);

    for (int r = 0; r < 12; r++) do_run("rand", $urandom_range(1, 40), 0, 1'b0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    do_run("t5", 15, 2, 1'b1);
    check("t5_s_fwd_const", s_fwd_cnt, 15);
    check("t5_s_sat_const", s_sat, 1);
    check("t5_s_ret_const", s_retired_cnt, 15);

`ifdef PERF_WATCHDOG_EN
    do_run("t6", 10, 3, 1'b0);
    check("t6_timeout_const", timeout, 1);
    check("t6_ret_const", retired_cnt, 2);
    do_run("t6_restart", 3, 2, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "bench time limit");
  end

endmodule
